// File: rtl/mem_arbiter_rr_if.sv
// Requester-side and SRAM-side signal bundle for mem_arbiter_rr.
// req_lock exists only when MEM_ARB_LOCK_EN is defined.
interface mem_arbiter_rr_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
`ifdef MEM_ARB_LOCK_EN
  logic [NUM_REQ-1:0]            req_lock;
`endif
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic                          mem_ce;
  logic                          mem_we;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0]         mem_wdata;
  logic [DATA_WIDTH-1:0]         mem_rdata;

  // Arbiter side
  modport slave (
`ifdef MEM_ARB_LOCK_EN
    input  req_lock,
`endif
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, mem_ce, mem_we, mem_addr, mem_wdata
  );

  // Requester + SRAM environment side
  modport master (
`ifdef MEM_ARB_LOCK_EN
    output req_lock,
`endif
    output req_valid, req_we, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, mem_ce, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter_rr.sv
// Round-robin N-port arbiter onto a fixed-latency SRAM; SRAM command registered 1 cycle after accept, read
// response MEM_RD_LATENCY+2 cycles after accept; req_ready is the only backpressure. Grant lock under MEM_ARB_LOCK_EN.
module mem_arbiter_rr #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_RD_LATENCY = 1,
  parameter int LOCK_MAX       = 16
) (
  input logic             clk,
  input logic             rst_n,
  mem_arbiter_rr_if.slave bus
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int LAT  = MEM_RD_LATENCY;

  if (NUM_REQ < 2 || NUM_REQ > 16 || MEM_RD_LATENCY < 1 || MEM_RD_LATENCY > 4 || LOCK_MAX < 1)
  begin : g_bad_param
    $error("mem_arbiter_rr: parameter out of range");
  end

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == ID_W'(NUM_REQ - 1)) ? '0 : id + ID_W'(1);
  endfunction

  logic [ID_W-1:0]       ptr;
  logic [ID_W-1:0]       start;
  logic [ID_W:0]         cand;
  logic                  srch_vld;
  logic [ID_W-1:0]       srch_id;
  logic                  sel_vld;
  logic [ID_W-1:0]       sel_id;
  logic                  adv_ptr;
  logic [NUM_REQ-1:0]    grant;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [ID_W-1:0]       mem_id;
  logic [LAT-1:0]        tag_vld;
  logic [ID_W-1:0]       tag_id [LAT];
  logic [NUM_REQ-1:0]    rsp_hot;

  // Rotating priority search: first valid port at or after start, wrapping at NUM_REQ.
  always_comb begin
    srch_vld = 1'b0;
    srch_id  = '0;
    cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, start} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (!srch_vld && bus.req_valid[cand[ID_W-1:0]]) begin
        srch_vld = 1'b1;
        srch_id  = cand[ID_W-1:0];
      end
    end
  end

`ifdef MEM_ARB_LOCK_EN
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  logic [ID_W-1:0]  last_id;
  logic             last_vld;
  logic             last_live;
  logic             lock_hit;
  logic             hold;
  logic [CNT_W-1:0] lock_cnt;

  // The previous winner keeps the grant while it stays valid and locked, until LOCK_MAX
  // consecutive locked grants; then one arbitration starts just past it.
  assign last_live = last_vld && bus.req_valid[last_id] && bus.req_lock[last_id];
  assign lock_hit  = (lock_cnt == CNT_W'(LOCK_MAX));
  assign hold      = last_live && !lock_hit;
  assign start     = (last_live && lock_hit) ? next_id(last_id) : ptr;
  assign sel_vld   = hold || srch_vld;
  assign sel_id    = hold ? last_id : srch_id;
  assign adv_ptr   = srch_vld && !hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_id  <= '0;
      last_vld <= 1'b0;
      lock_cnt <= '0;
    end else if (sel_vld) begin
      last_id  <= sel_id;
      last_vld <= 1'b1;
      if ((last_live && lock_hit) || !bus.req_lock[sel_id]) begin
        lock_cnt <= '0;
      end else if (last_vld && sel_id == last_id) begin
        if (!lock_hit) begin
          lock_cnt <= lock_cnt + CNT_W'(1);
        end
      end else begin
        lock_cnt <= CNT_W'(1);
      end
    end else if (last_vld && !bus.req_valid[last_id]) begin
      lock_cnt <= '0;
    end
  end
`else
  assign start   = ptr;
  assign sel_vld = srch_vld;
  assign sel_id  = srch_id;
  assign adv_ptr = srch_vld;
`endif

  always_comb begin
    grant     = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_vld && sel_id == ID_W'(i)) begin
        grant[i]  = 1'b1;
        sel_we    = bus.req_we[i];
        sel_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign bus.req_ready = grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (adv_ptr) begin
      ptr <= next_id(sel_id);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_ce    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      mem_id        <= '0;
    end else begin
      bus.mem_ce <= sel_vld;
      bus.mem_we <= sel_vld && sel_we;
      if (sel_vld) begin
        bus.mem_addr  <= sel_addr;
        bus.mem_wdata <= sel_wdata;
        mem_id        <= sel_id;
      end
    end
  end

  // Port id of each outstanding read rides alongside the SRAM pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld <= '0;
      for (int s = 0; s < LAT; s++) begin
        tag_id[s] <= '0;
      end
    end else begin
      tag_vld[0] <= bus.mem_ce && !bus.mem_we;
      tag_id[0]  <= mem_id;
      for (int s = 1; s < LAT; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_id[s]  <= tag_id[s-1];
      end
    end
  end

  always_comb begin
    rsp_hot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (tag_vld[LAT-1] && tag_id[LAT-1] == ID_W'(i)) begin
        rsp_hot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid <= '0;
      bus.rsp_rdata <= '0;
    end else begin
      bus.rsp_valid <= rsp_hot;
      if (tag_vld[LAT-1]) begin
        bus.rsp_rdata <= bus.mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: two instances (read latency 1 and 3) share one request stream; each is
// checked against a queue/shadow-memory reference model plus directed sequences.
module tb_mem_arbiter_rr;
  localparam int N        = 4;
  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int LOCK_MAX = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arbiter_rr_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
  mem_arbiter_rr_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus3 ();

  mem_arbiter_rr #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_RD_LATENCY(1), .LOCK_MAX(LOCK_MAX))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  mem_arbiter_rr #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_RD_LATENCY(3), .LOCK_MAX(LOCK_MAX))
    u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  // Requester stimulus, shared by both instances
  logic [N-1:0]  v, we, lk;
  logic [AW-1:0] a  [N];
  logic [DW-1:0] wd [N];

  assign bus1.req_valid = v;
  assign bus3.req_valid = v;
  assign bus1.req_we    = we;
  assign bus3.req_we    = we;
`ifdef MEM_ARB_LOCK_EN
  assign bus1.req_lock  = lk;
  assign bus3.req_lock  = lk;
`endif
  always_comb begin
    bus1.req_addr  = '0;
    bus1.req_wdata = '0;
    bus3.req_addr  = '0;
    bus3.req_wdata = '0;
    for (int i = 0; i < N; i++) begin
      bus1.req_addr[i*AW +: AW]  = a[i];
      bus3.req_addr[i*AW +: AW]  = a[i];
      bus1.req_wdata[i*DW +: DW] = wd[i];
      bus3.req_wdata[i*DW +: DW] = wd[i];
    end
  end

  function automatic logic [DW-1:0] seed(input int idx);
    return (idx == 'h40) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(idx));
  endfunction

  // SRAM models, 256 words indexed by mem_addr[7:0]
  logic [DW-1:0] sram1 [256];
  logic [DW-1:0] sram3 [256];
  logic [DW-1:0] r3a, r3b;
  bit init1 = 1'b0;
  bit init3 = 1'b0;

  always @(posedge clk) begin
    if (!init1) begin
      for (int i = 0; i < 256; i++) sram1[i] <= seed(i);
      init1 = 1'b1;
    end
    bus1.mem_rdata <= sram1[bus1.mem_addr[7:0]];
    if (bus1.mem_ce && bus1.mem_we) sram1[bus1.mem_addr[7:0]] <= bus1.mem_wdata;
  end

  always @(posedge clk) begin
    if (!init3) begin
      for (int i = 0; i < 256; i++) sram3[i] <= seed(i);
      init3 = 1'b1;
    end
    r3a            <= sram3[bus3.mem_addr[7:0]];
    r3b            <= r3a;
    bus3.mem_rdata <= r3b;
    if (bus3.mem_ce && bus3.mem_we) sram3[bus3.mem_addr[7:0]] <= bus3.mem_wdata;
  end

  // Reference model
  typedef struct packed {
    int            due;
    int            port;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          q1[$];
  rsp_t          q3[$];
  logic [DW-1:0] shadow [256];
  int            m_ptr, last_w, cyc;
  logic          e_ce, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_rd1, e_rd3;
  logic [N-1:0]  g_obs;
  int            n_chk = 0;
  int            n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] vv, input int p);
    for (int k = 0; k < N; k++) begin
      if (vv[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    q1.delete();
    q3.delete();
    m_ptr   = 0;
    last_w  = -1;
    e_ce    = 1'b0;
    e_we    = 1'b0;
    e_addr  = '0;
    e_wdata = '0;
    e_rd1   = '0;
    e_rd3   = '0;
  endtask

  // One cycle: check at negedge, advance the model across the next posedge, return at posedge+1.
  task automatic step();
    int           w;
    logic [N-1:0] g, e1, e3;
    @(negedge clk);
    w = rr_pick(v, m_ptr);
    g = '0;
    if (w >= 0) g[w] = 1'b1;
    g_obs = bus1.req_ready;
    chk("ready_l1", bus1.req_ready, g);
    chk("ready_l3", bus3.req_ready, g);
    chk("mem_ce_l1", bus1.mem_ce, e_ce);
    chk("mem_ce_l3", bus3.mem_ce, e_ce);
    chk("mem_we_l1", bus1.mem_we, e_we);
    chk("mem_we_l3", bus3.mem_we, e_we);
    chk("mem_addr_l1", bus1.mem_addr, e_addr);
    chk("mem_addr_l3", bus3.mem_addr, e_addr);
    chk("mem_wdata_l1", bus1.mem_wdata, e_wdata);
    e1 = '0;
    if (q1.size() > 0 && q1[0].due == cyc) begin
      e1[q1[0].port] = 1'b1;
      e_rd1 = q1[0].data;
      void'(q1.pop_front());
    end
    e3 = '0;
    if (q3.size() > 0 && q3[0].due == cyc) begin
      e3[q3[0].port] = 1'b1;
      e_rd3 = q3[0].data;
      void'(q3.pop_front());
    end
    chk("rsp_valid_l1", bus1.rsp_valid, e1);
    chk("rsp_valid_l3", bus3.rsp_valid, e3);
    chk("rsp_rdata_l1", bus1.rsp_rdata, e_rd1);
    chk("rsp_rdata_l3", bus3.rsp_rdata, e_rd3);
    e_ce   = (w >= 0);
    e_we   = 1'b0;
    last_w = w;
    if (w >= 0) begin
      e_we    = we[w];
      e_addr  = a[w];
      e_wdata = wd[w];
      if (we[w]) begin
        shadow[a[w][7:0]] = wd[w];
      end else begin
        q1.push_back('{due: cyc + 3, port: w, data: shadow[a[w][7:0]]});
        q3.push_back('{due: cyc + 5, port: w, data: shadow[a[w][7:0]]});
      end
      m_ptr = (w + 1) % N;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    v = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_ready", bus1.req_ready, 4'b0000);
    chk("rst_mem_ce", bus1.mem_ce, 1'b0);
    chk("rst_mem_we", bus1.mem_we, 1'b0);
    chk("rst_mem_addr", bus1.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus1.mem_wdata, 32'h0);
    chk("rst_rsp_valid_l1", bus1.rsp_valid, 4'b0000);
    chk("rst_rsp_rdata_l1", bus1.rsp_rdata, 32'h0);
    chk("rst_rsp_valid_l3", bus3.rsp_valid, 4'b0000);
    chk("rst_mem_ce_l3", bus3.mem_ce, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int p, input logic wr, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    v[p]  = 1'b1;
    we[p] = wr;
    a[p]  = ad;
    wd[p] = d;
  endtask

  task automatic drain(input int n);
    v = '0;
    repeat (n) step();
  endtask

  initial begin
    rst_n = 1'b1;
    v     = '0;
    we    = '0;
    lk    = '0;
    cyc   = 0;
    g_obs = '0;
    for (int i = 0; i < N; i++) begin
      a[i]  = '0;
      wd[i] = '0;
    end
    for (int i = 0; i < 256; i++) shadow[i] = seed(i);
    model_reset();
    #2;
    do_reset();

    // All ports continuously valid from ptr=0: strict 0,1,2,3 rotation
    for (int i = 0; i < N; i++) put(i, 1'b0, 32'($urandom_range(0, 15)) * 4, $urandom);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr_order", g_obs, 4'b0001 << (k % 4));
      if (last_w >= 0) put(last_w, 1'b0, 32'($urandom_range(0, 15)) * 4, $urandom);
    end
    drain(6);

    // Single read from port 2
    put(2, 1'b0, 32'h40, 32'h0);
    step();
    drain(5);
    chk("single_read_data", bus1.rsp_rdata, 32'hDEADBEEF);

    // Write then read of the same address from different ports
    put(0, 1'b1, 32'h8, 32'h11);
    step();
    v = '0;
    put(1, 1'b0, 32'h8, 32'h0);
    step();
    drain(6);
    chk("wr_rd_data_l1", bus1.rsp_rdata, 32'h11);
    chk("wr_rd_data_l3", bus3.rsp_rdata, 32'h11);

    // Back-to-back reads from ports 3,1,0
    put(3, 1'b0, 32'h10, 32'h0);
    step();
    v = '0;
    put(1, 1'b0, 32'h14, 32'h0);
    step();
    v = '0;
    put(0, 1'b0, 32'h8, 32'h0);
    step();
    drain(7);

    // Reset right after two reads are accepted: their responses must never appear
    put(0, 1'b0, 32'h4, 32'h0);
    put(1, 1'b0, 32'h8, 32'h0);
    step();
    v[last_w] = 1'b0;
    step();
    do_reset();
    drain(7);

    // Randomized traffic honouring the hold-while-not-ready rule
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] || i == last_w) begin
          v[i]  = ($urandom_range(0, 2) != 0);
          we[i] = ($urandom_range(0, 2) == 0);
          a[i]  = 32'($urandom_range(0, 15)) * 4;
          wd[i] = $urandom;
        end
      end
      step();
    end
    drain(7);

`ifdef MEM_ARB_LOCK_EN
    // Port 1 locked against port 2: four grants to 1, one to 2, repeat
    do_reset();
    put(1, 1'b0, 32'h4, 32'h0);
    put(2, 1'b0, 32'h8, 32'h0);
    lk = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("lock_seq_l1", bus1.req_ready, (k % 5 == 4) ? 4'b0100 : 4'b0010);
      chk("lock_seq_l3", bus3.req_ready, (k % 5 == 4) ? 4'b0100 : 4'b0010);
      @(posedge clk);
      #1;
    end
    lk = '0;
    v  = '0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
